// File: rtl/mem_arbiter_pkg.sv
// Shared width/state constants and the arbiter FSM state type.
// The `define block stands in for the project-wide define header so it is visible to later files.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef ST_IDLE
`define ST_IDLE 2'd0
`endif
`ifndef ST_OWN0
`define ST_OWN0 2'd1
`endif
`ifndef ST_OWN1
`define ST_OWN1 2'd2
`endif

package mem_arbiter_pkg;

  // State names the owner of the previous cycle's grant.
  typedef enum logic [1:0] {
    IDLE = `ST_IDLE,
    OWN0 = `ST_OWN0,
    OWN1 = `ST_OWN1
  } state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-master single-port memory arbiter.
// Provides round-robin arbitration, bounded lock bursts and a registered read return.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DW        = `DATA_WIDTH,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [DW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_rvalid,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [DW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_rvalid,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(MAX_BURST + 1);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c >= CW'(MAX_BURST)) ? c : c + 1'b1;
  endfunction

  state_t        state, state_nxt;
  logic          rr_ptr, rr_nxt;
  logic          lock_q, lock_nxt;
  logic [CW-1:0] burst_cnt, cnt_nxt;
  logic          win1;
  logic          any_req;
  logic          lock_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      lock_q    <= 1'b0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_nxt;
      lock_q    <= lock_nxt;
      burst_cnt <= cnt_nxt;
    end
  end

  // Once the burst limit is reached, lock is ignored and the pointer decides.
  always_comb begin
    state_nxt = IDLE;
    rr_nxt    = rr_ptr;
    lock_nxt  = 1'b0;
    cnt_nxt   = '0;
    win1      = 1'b0;
    any_req   = m0_req | m1_req;
    lock_hold = lock_q && (state != IDLE) && (burst_cnt < CW'(MAX_BURST));

    if (m0_req && m1_req) begin
      if (lock_hold) win1 = (state == OWN1);
      else           win1 = rr_ptr;
    end else begin
      win1 = m1_req;
    end

    if (any_req) begin
      state_nxt = win1 ? OWN1 : OWN0;
      rr_nxt    = ~win1;
      lock_nxt  = win1 ? m1_lock : m0_lock;
      cnt_nxt   = (state == state_nxt) ? sat_inc(burst_cnt) : CW'(1);
    end
  end

  assign m0_gnt    = rst_n & m0_req & ~win1;
  assign m1_gnt    = rst_n & m1_req & win1;
  assign mem_addr  = m1_gnt ? m1_addr : m0_addr;
  assign mem_wdata = m1_gnt ? m1_wdata : m0_wdata;
  assign mem_we    = (m0_gnt & m0_we) | (m1_gnt & m1_we);

  // Read return: one-cycle latency, data holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= m0_gnt & ~m0_we;
      m1_rvalid <= m1_gnt & ~m1_we;
      if (m0_gnt && !m0_we) m0_rdata <= mem_rdata;
      if (m1_gnt && !m1_we) m1_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural memory behind the shared port.
module tb_mem_arbiter;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_req, m0_we, m0_lock;
  logic [DW-1:0] m0_addr, m0_wdata, m0_rdata;
  logic          m0_gnt, m0_rvalid;
  logic          m1_req, m1_we, m1_lock;
  logic [DW-1:0] m1_addr, m1_wdata, m1_rdata;
  logic          m1_gnt, m1_rvalid;
  logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
  logic          mem_we;
  logic          preload;

  logic [DW-1:0] mem [256];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (preload) mem[8'h10] <= 16'h1234;
    else if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
  end

  mem_arbiter #(.DW(DW), .MAX_BURST(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    rst_n   = 1'b0;
    preload = 1'b1;
    m0_req  = 1'b1;
    m1_req  = 1'b1;
    m0_we   = 1'b1;
    #1;
    chk("rst_m0_gnt", m0_gnt, 0);
    chk("rst_m1_gnt", m1_gnt, 0);
    chk("rst_mem_we", mem_we, 0);
    @(posedge clk); #1;
    chk("rst_m0_rvalid", m0_rvalid, 0);
    chk("rst_m1_rvalid", m1_rvalid, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_m1_rdata", m1_rdata, 0);
    preload = 1'b0;
    idle_inputs();
    rst_n = 1'b1;

    // Single read from m0.
    m0_req = 1; m0_addr = 16'h0010;
    #1;
    chk("rd_m0_gnt", m0_gnt, 1);
    chk("rd_m1_gnt", m1_gnt, 0);
    chk("rd_mem_addr", mem_addr, 16'h0010);
    chk("rd_mem_we", mem_we, 0);
    @(posedge clk); #1;
    chk("rd_m0_rvalid", m0_rvalid, 1);
    chk("rd_m0_rdata", m0_rdata, 16'h1234);
    chk("rd_m1_rvalid", m1_rvalid, 0);
    m0_req = 0; m0_addr = 16'h0055;
    #1;
    chk("idle_m0_gnt", m0_gnt, 0);
    chk("idle_mem_addr", mem_addr, 16'h0055);
    @(posedge clk); #1;
    chk("idle_m0_rvalid", m0_rvalid, 0);
    chk("hold_m0_rdata", m0_rdata, 16'h1234);

    // Round-robin alternation with both requesting, no lock.
    do_reset();
    m0_req = 1; m0_addr = 16'h0010;
    m1_req = 1; m1_addr = 16'h0011;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_m0_gnt_%0d", i), m0_gnt, (i % 2 == 0));
      chk($sformatf("rr_m1_gnt_%0d", i), m1_gnt, (i % 2 == 1));
      @(posedge clk); #1;
      chk($sformatf("rr_m0_rvalid_%0d", i), m0_rvalid, (i % 2 == 0));
      chk($sformatf("rr_m1_rvalid_%0d", i), m1_rvalid, (i % 2 == 1));
    end

    // Locked burst hits the limit of 8, then m1 (also locking) keeps the grant.
    do_reset();
    m0_req = 1; m0_lock = 1; m0_addr = 16'h0010;
    m1_req = 1; m1_lock = 1; m1_addr = 16'h0011;
    for (int i = 0; i < 11; i++) begin
      if (i == 10) m1_req = 0;
      #1;
      chk($sformatf("burst_m0_gnt_%0d", i), m0_gnt, (i < 8) || (i == 10));
      chk($sformatf("burst_m1_gnt_%0d", i), m1_gnt, (i == 8) || (i == 9));
      @(posedge clk); #1;
    end

    // Write from m1 then read-back by m0.
    do_reset();
    m1_req = 1; m1_we = 1; m1_addr = 16'h0020; m1_wdata = 16'hBEEF;
    #1;
    chk("wr_m1_gnt", m1_gnt, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_wdata", mem_wdata, 16'hBEEF);
    chk("wr_mem_addr", mem_addr, 16'h0020);
    @(posedge clk); #1;
    chk("wr_m1_rvalid", m1_rvalid, 0);
    m1_req = 0; m1_we = 0;
    m0_req = 1; m0_addr = 16'h0020;
    #1;
    chk("wrrd_m0_gnt", m0_gnt, 1);
    @(posedge clk); #1;
    chk("wrrd_m0_rvalid", m0_rvalid, 1);
    chk("wrrd_m0_rdata", m0_rdata, 16'hBEEF);
    chk("wrrd_m1_rvalid", m1_rvalid, 0);

    // Reset during a read grant drops the return; pointer restarts at m0.
    do_reset();
    m0_req = 1; m0_addr = 16'h0010;
    #1;
    chk("rr_rst_m0_gnt", m0_gnt, 1);
    rst_n = 1'b0;
    #1;
    chk("rr_rst_gated_gnt", m0_gnt, 0);
    @(posedge clk); #1;
    chk("rr_rst_m0_rvalid", m0_rvalid, 0);
    chk("rr_rst_m0_rdata", m0_rdata, 0);
    rst_n = 1'b1;
    m1_req = 1; m1_addr = 16'h0011;
    #1;
    chk("post_rst_m0_gnt", m0_gnt, 1);
    chk("post_rst_m1_gnt", m1_gnt, 0);
    @(posedge clk); #1;
    chk("post_rst_m0_rvalid", m0_rvalid, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
